imem_loader: RTL

Boot-time writer for the instruction memory that the single-cycle core fetches from. It receives a byte stream over a valid/ready handshake from a host link (UART receiver or testbench). It assembles little-endian 32-bit instruction words and writes them into the instruction memory write port. It holds the core in reset until the image is loaded and its checksum verifies.

---
 rtl/imem_loader_pkg.sv | 5 +
 rtl/imem_loader_word_assembler.sv | 49 ++++
 rtl/imem_loader.sv | 96 +++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared loader state encoding and stream constants.
package imem_loader_pkg;
    typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, CHECK, DONE, ERROR} state_e;
    localparam int HDR_BYTES = 2;
endpackage

// File: rtl/imem_loader_word_assembler.sv
// ld_word_assembler: packs payload bytes LSB-first into 32-bit words,
// issues the one-cycle write strobe and keeps the running payload XOR.
module ld_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic        word_done_o,
    output logic [31:0] wdata_o,
    output logic        wen_o,
    output logic [7:0]  csum_o
);
    logic [1:0]  lane_q, lane_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wen_q, wen_d;
    logic [7:0]  csum_q, csum_d;

    assign word_done_o = byte_en_i && lane_q == 2'd3;
    assign wdata_o     = wdata_q;
    assign wen_o       = wen_q;
    assign csum_o      = csum_q;

    // After three bytes shift_q holds {b2,b1,b0}, so the lane-3 byte completes the word directly.
    always_comb begin
        lane_d  = clear_i ? 2'd0 : byte_en_i ? lane_q + 2'd1 : lane_q;
        shift_d = byte_en_i ? {byte_i, shift_q[23:8]} : shift_q;
        wdata_d = word_done_o ? {byte_i, shift_q} : wdata_q;
        wen_d   = word_done_o;
        csum_d  = clear_i ? 8'd0 : byte_en_i ? csum_q ^ byte_i : csum_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q  <= '0;
            shift_q <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            csum_q  <= '0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            csum_q  <= csum_d;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader that streams a checksummed image into instruction
// memory and holds the core in reset until the image verifies.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              LDstart,
    input  logic [7:0]        LDbyte,
    input  logic              LDvalid,
    output logic              LDready,
    output logic [ADDR_W-1:0] IMwaddr,
    output logic [31:0]       IMwdata,
    output logic              IMwenable,
    output logic              LDcpu_hold,
    output logic              LDdone,
    output logic              LDerror
);
    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    state_e            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [ADDR_W:0]   word_q, word_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              hs, clear, word_done;
    logic [7:0]        csum;

    assign LDready    = state_q inside {HDR_LO, HDR_HI, DATA, CHECK};
    assign LDcpu_hold = state_q != DONE;
    assign LDdone     = state_q == DONE;
    assign LDerror    = state_q == ERROR;
    assign IMwaddr    = waddr_q;
    assign hs         = LDvalid && LDready;

    ld_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (reset),
        .clear_i    (clear),
        .byte_en_i  (hs && state_q == DATA),
        .byte_i     (LDbyte),
        .word_done_o(word_done),
        .wdata_o    (IMwdata),
        .wen_o      (IMwenable),
        .csum_o     (csum)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        word_d  = word_q;
        waddr_d = waddr_q;
        clear   = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: if (LDstart) begin
                state_d = HDR_LO;
                n_d     = '0;
                word_d  = '0;
                clear   = 1'b1;
            end
            HDR_LO: if (hs) begin
                n_d[7:0] = LDbyte;
                state_d  = HDR_HI;
            end
            HDR_HI: if (hs) begin
                n_d[15:8] = LDbyte;
                state_d   = ({1'b0, LDbyte, n_q[7:0]} > CAP) ? ERROR :
                            ({LDbyte, n_q[7:0]} == 16'd0) ? CHECK : DATA;
            end
            // Address is latched with the word so it lines up with the registered strobe.
            DATA: if (word_done) begin
                word_d  = word_q + (ADDR_W+1)'(1);
                waddr_d = ADDR_W'(BASE_ADDR) + word_q[ADDR_W-1:0];
                state_d = (17'(word_d) == 17'(n_q)) ? CHECK : DATA;
            end
            CHECK: if (hs) state_d = (LDbyte == csum) ? DONE : ERROR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            word_q  <= '0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            word_q  <= word_d;
            waddr_q <= waddr_d;
        end
    end
endmodule
